// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 3-bit-opcode ALU: it accepts instructions over valid/ready,
// runs ALU ops through a timed EXEC window and handles NOP/LOAD/OUT/HALT locally.
module alu_sequencer #(
    parameter int         EXEC_CYCLES = 2,
    parameter logic [9:0] ACC_RESET   = 10'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [10:0] instr,
    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_in1,
    output logic [9:0]  alu_in2,
    input  logic [9:0]  alu_out,
    input  logic        alu_flag,
    output logic [9:0]  acc,
    output logic        flag,
    output logic        out_valid,
    output logic [9:0]  out_data,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_INC   = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;
    localparam logic [2:0] OP_OUT   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [9:0]  acc_reg, acc_next;
    logic        flag_reg, flag_next;
    logic [2:0]  alu_opcode_reg, alu_opcode_next;
    logic [7:0]  alu_in1_reg, alu_in1_next;
    logic [9:0]  alu_in2_reg, alu_in2_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        out_valid_reg, out_valid_next;
    logic [9:0]  out_data_reg, out_data_next;

    logic [2:0]  op;
    logic [7:0]  imm;

    assign op  = instr[10:8];
    assign imm = instr[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            acc_reg        <= ACC_RESET;
            flag_reg       <= (ACC_RESET != 10'd0);
            alu_opcode_reg <= OP_NOP;
            alu_in1_reg    <= 8'd0;
            alu_in2_reg    <= 10'd0;
            cnt_reg        <= 4'd0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 10'd0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            flag_reg       <= flag_next;
            alu_opcode_reg <= alu_opcode_next;
            alu_in1_reg    <= alu_in1_next;
            alu_in2_reg    <= alu_in2_next;
            cnt_reg        <= cnt_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        flag_next       = flag_reg;
        alu_opcode_next = alu_opcode_reg;
        alu_in1_next    = alu_in1_reg;
        alu_in2_next    = alu_in2_reg;
        cnt_next        = cnt_reg;
        out_valid_next  = 1'b0;
        out_data_next   = out_data_reg;

        case (state_reg)
            IDLE: begin
                if (instr_valid) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_INC, OP_SHIFT: begin
                            alu_opcode_next = op;
                            alu_in1_next    = imm;
                            alu_in2_next    = acc_reg;
                            cnt_next        = 4'd0;
                            state_next      = EXEC;
                        end
                        OP_LOAD: begin
                            acc_next  = {2'b00, imm};
                            flag_next = (imm != 8'd0);
                        end
                        OP_OUT: begin
                            out_valid_next = 1'b1;
                            out_data_next  = acc_reg;
                        end
                        OP_HALT: state_next = HALT;
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                // The ALU flag lags out1 by one negedge, so capture waits for both to settle.
                if (cnt_reg == LAST_CNT) begin
                    acc_next        = alu_out;
                    flag_next       = alu_flag;
                    alu_opcode_next = OP_NOP;
                    state_next      = IDLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HALT: ;
            default: state_next = IDLE;
        endcase
    end

    assign instr_ready = (state_reg == IDLE);
    assign halted      = (state_reg == HALT);
    assign alu_opcode  = alu_opcode_reg;
    assign alu_in1     = alu_in1_reg;
    assign alu_in2     = alu_in2_reg;
    assign acc         = acc_reg;
    assign flag        = flag_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a negedge ALU model closes the loop; OUT pulses are checked
// against a scoreboard queue, and control signals are checked directly.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [10:0] instr = 11'd0;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_in1;
    logic [9:0]  alu_in2;
    logic [9:0]  alu_out = 10'd0;
    logic        alu_flag = 1'b0;
    logic [9:0]  acc;
    logic        flag;
    logic        out_valid;
    logic [9:0]  out_data;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_q[$];

    alu_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_flag(alu_flag), .acc(acc), .flag(flag),
        .out_valid(out_valid), .out_data(out_data), .halted(halted)
    );

    always #5 clk = ~clk;

    // ALU model: out1 updates on negedge; flag follows the previous out1.
    always @(negedge clk) begin
        alu_flag <= (alu_out != 10'd0);
        case (alu_opcode)
            3'b001: alu_out <= alu_in2 + {2'b00, alu_in1};
            3'b010: alu_out <= alu_in2 - {2'b00, alu_in1};
            3'b011: alu_out <= alu_in2 + 10'd1;
            3'b100: alu_out <= alu_in2 >> 2;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor for OUT pulses.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_pulse: got out_data %0h expected no pulse", out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_bad++;
                    $display("FAIL out_data: got %0h expected %0h", out_data, e);
                end else begin
                    $display("out   data=%0d ok", out_data);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] imm);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("issue_ready_timeout", 0, 1);
        instr_valid = 1'b1;
        instr = {op, imm};
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        $display("instr op=%0d imm=%0d -> acc=%0d flag=%0b", op, imm, acc, flag);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", instr_ready, 1);
    endtask

    task automatic out_op(input logic [9:0] expect_val);
        exp_q.push_back(expect_val);
        issue(3'b110, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_acc", acc, 0);
        chk("rst_opcode", alu_opcode, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flag", flag, 0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_halted", halted, 0);
        chk("rst_out_valid", out_valid, 0);

        // LOAD
        issue(3'b101, 8'd5);
        chk("load5_acc", acc, 5);
        chk("load5_flag", flag, 1);
        chk("load5_ready", instr_ready, 1);
        issue(3'b101, 8'd0);
        chk("load0_acc", acc, 0);
        chk("load0_flag", flag, 0);
        issue(3'b101, 8'd5);

        // ADD 3 with timing checks
        issue(3'b001, 8'd3);
        chk("add_p0_ready", instr_ready, 0);
        chk("add_p0_opcode", alu_opcode, 3'b001);
        chk("add_p0_in1", alu_in1, 3);
        chk("add_p0_in2", alu_in2, 5);
        @(posedge clk); #1;
        chk("add_p1_ready", instr_ready, 0);
        chk("add_p1_opcode", alu_opcode, 3'b001);
        chk("add_p1_acc", acc, 5);
        @(posedge clk); #1;
        chk("add_p2_acc", acc, 8);
        chk("add_p2_flag", flag, 1);
        chk("add_p2_opcode", alu_opcode, 0);
        chk("add_p2_ready", instr_ready, 1);
        out_op(10'd8);

        // SUB wrap, then INC wrap with lagging flag
        issue(3'b010, 8'd9);
        wait_idle();
        chk("sub_acc", acc, 10'h3FF);
        chk("sub_flag", flag, 1);
        issue(3'b011, 8'd0);
        wait_idle();
        chk("inc_acc", acc, 0);
        chk("inc_flag", flag, 0);
        out_op(10'd0);

        // SHIFT, back-to-back OUT
        issue(3'b101, 8'd200);
        issue(3'b100, 8'd7);
        wait_idle();
        chk("shift_acc", acc, 50);
        chk("shift_in1", alu_in1, 7);
        out_op(10'd50);
        out_op(10'd50);
        issue(3'b000, 8'd0);
        chk("nop_acc", acc, 50);

        // HALT ignores a held instruction
        issue(3'b111, 8'd0);
        instr_valid = 1'b1;
        instr = {3'b001, 8'd1};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_halted", halted, 1);
            chk("halt_ready", instr_ready, 0);
            chk("halt_acc", acc, 50);
        end
        rst = 1'b1;
        #1;
        chk("halt_rst_acc", acc, 0);
        chk("halt_rst_halted", halted, 0);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("halt_rst_ready", instr_ready, 1);

        // Reset mid-EXEC
        issue(3'b101, 8'd7);
        issue(3'b001, 8'd1);
        chk("midrst_opcode_pre", alu_opcode, 3'b001);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_opcode", alu_opcode, 0);
        chk("midrst_acc", acc, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'b001, 8'd4);
        wait_idle();
        chk("post_rst_add_acc", acc, 4);
        out_op(10'd4);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control-side counterpart of the 3-bit-opcode ALU. It accepts 11-bit instructions over a valid/ready handshake and drives opcode and operands to the ALU. It holds them across the ALU's negedge update and captures the ALU result and flag back into an accumulator. It also executes non-ALU instructions (NOP, LOAD, OUT, HALT) internally, and sits between the instruction source and the ALU.

Parameters:
EXEC_CYCLES, 2, posedges spent in EXEC before capture; legal range 2..15; 2 is the minimum needed for alu_flag to reflect the new result.
ACC_RESET, 10'd0, accumulator value after reset.

Ports:
clk  input  1  system clock; ALU side samples on negedge, this block on posedge
rst  input  1  asynchronous reset, active-high
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept; high only in IDLE
instr  input  11  [10:8] opcode, [7:0] imm
alu_opcode  output  3  to ALU opcode
alu_in1  output  8  to ALU in1 (imm)
alu_in2  output  10  to ALU in2 (accumulator)
alu_out  input  10  from ALU out1
alu_flag  input  1  from ALU flag
acc  output  10  accumulator
flag  output  1  registered nonzero flag of last result
out_valid  output  1  one-cycle pulse on OUT
out_data  output  10  accumulator value emitted by OUT
halted  output  1  high in HALT state

Behaviour:
- Reset, asynchronous, all outputs:
  - state=IDLE, acc=ACC_RESET, flag=(ACC_RESET!=0), alu_opcode=3'b000, alu_in1=0, alu_in2=0.
  - out_valid=0, out_data=0, halted=0, internal cycle counter=0.
- The ALU has no reset. Its out1/flag are never consumed before the first EXEC capture.
- Opcodes:
  - 000 NOP.
  - 001 ADD, 010 SUB, 011 INC, 100 SHIFT: ALU ops.
  - 101 LOAD.
  - 110 OUT.
  - 111 HALT.
- instr_ready = (state==IDLE). This is combinational from state. Accept = instr_valid & instr_ready at posedge.
- IDLE accepting an ALU op:
  - Register alu_opcode=op, alu_in1=imm, alu_in2=acc, counter=0; go to EXEC.
  - Outputs stay stable for the whole of EXEC.
- EXEC:
  - Counter increments each posedge.
  - On the posedge where counter==EXEC_CYCLES-1: acc<=alu_out, flag<=alu_flag, alu_opcode<=000, go to IDLE.
  - With EXEC_CYCLES=2: accepted at P0, acc valid after P2, next accept possible at P3 (3-cycle ALU throughput).
  - Rationale: the ALU updates out1 at the negedge after P0. Its flag lags one negedge, so it reflects the new out1 only at the negedge after P1. Holding the opcode through the second negedge recomputes an identical out1 because in2 is unchanged.
- LOAD: single cycle, stay in IDLE; acc<={2'b00,imm}, flag<=(imm!=0); no ALU activity.
- NOP: single cycle, no state change.
- OUT: single cycle; out_data<=acc, out_valid=1 for exactly one cycle, otherwise 0. Back-to-back OUTs give consecutive pulses.
- HALT: go to HALT; instr_ready=0, halted=1; instr_valid is ignored. Only rst exits HALT.
- Arithmetic: all 10-bit and produced by the ALU; the sequencer adds no saturation.
  - SUB wraps (8-1... 0-1 = 10'h3FF). INC wraps 10'h3FF to 0.
  - SHIFT is a logical right shift by 2 with imm ignored. imm is still driven on alu_in1.
- alu_opcode is 000 in every state except EXEC, so the ALU holds out1 while idle.
- Reset mid-EXEC: the op is abandoned, acc=ACC_RESET, and alu_opcode drops to 000 immediately, without waiting for clk.
- instr_valid during EXEC or HALT: not accepted. The source must hold instr until ready.

Test Plan:
- Reset, then LOAD imm=5 -> next posedge acc=5, flag=1, instr_ready stays high; then LOAD imm=0 -> acc=0, flag=0.
- acc=5, ADD imm=3 at P0 -> instr_ready low P0..P2, alu_opcode=001 / alu_in1=3 / alu_in2=5 during EXEC, acc=8 and flag=1 after P2, alu_opcode=000 after P2.
- acc=8, SUB imm=9 -> acc=10'h3FF, flag=1; then INC -> acc=0, flag=0 (checks wrap and the lagging-flag timing).
- LOAD 200, then SHIFT imm=7 -> acc=50; then OUT -> out_valid high exactly one cycle with out_data=50.
- HALT with instr_valid held high and ADD presented -> halted=1, instr_ready=0, acc unchanged for 20 cycles; rst -> IDLE, acc=0.
- ADD accepted, rst asserted mid-cycle between P0 and P1 -> alu_opcode=000 and acc=0 before the next clk edge; after release, first accept behaves normally.
